msg_pad_engine: RTL and testbench
=================================

MSG_PAD_ENGINE -- requirements
Module: msg_pad_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning the byte-address width of the message memory.
REQ-002 SHALL have parameter BLOCK_BYTES, default 64, meaning the padded block size in bytes; it is a power of two and at least 16.
REQ-003 SHALL have parameter LEN_BYTES, default 8, meaning the width in bytes of the trailing length field; it is at most BLOCK_BYTES-1.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic triggers on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: request to pad one message; sampled only in IDLE.
REQ-007 SHALL have port base_addr, input, ADDR_WIDTH bits: byte address of message byte 0.
REQ-008 SHALL have port msg_len, input, ADDR_WIDTH bits: message length in bytes.
REQ-009 SHALL have port mem_we, output, 1 bit: write request.
REQ-010 SHALL have port mem_addr, output, ADDR_WIDTH bits: write byte address.
REQ-011 SHALL have port mem_wdata, output, 8 bits: write data.
REQ-012 SHALL have port mem_ready, input, 1 bit: memory accepts the write this cycle.
REQ-013 SHALL have port busy, output, 1 bit: high while not in IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse on successful completion.
REQ-015 SHALL have port error, output, 1 bit: one-cycle pulse when the request is rejected.
REQ-016 SHALL have port num_blocks, output, ADDR_WIDTH bits: padded block count, valid from done until the next start.

Function
REQ-017 SHALL latch base_addr and msg_len on start in IDLE; start while busy is ignored.
REQ-018 SHALL compute padded length P as the smallest multiple of BLOCK_BYTES that is at least msg_len+1+LEN_BYTES, using ADDR_WIDTH+2-bit arithmetic with no truncation.
REQ-019 SHALL reject the request if base_addr+P > 2^ADDR_WIDTH: error pulses one cycle after start, no write is issued, and the block returns to IDLE.
REQ-020 SHALL use states IDLE -> CALC -> PAD80 -> ZERO -> LEN -> FIN -> IDLE, with ZERO skipped when the zero count is 0.
REQ-021 SHALL issue the writes in this order: 0x80 at base+msg_len; P-msg_len-1-LEN_BYTES bytes of 0x00 at ascending addresses; then the LEN_BYTES field at base+P-LEN_BYTES .. base+P-1.
REQ-022 SHALL set the length field to msg_len*8 in bits, zero-extended to LEN_BYTES*8 bits, most-significant byte first.
REQ-023 SHALL make the first mem_we assertion 2 cycles after the start cycle (start edge, CALC, then PAD80 drives).
REQ-024 SHALL complete a write only on a cycle with mem_we and mem_ready both high; while mem_ready is low, mem_we, mem_addr and mem_wdata hold stable.
REQ-025 SHALL sustain one completed write per cycle with no bubbles across state changes while mem_ready stays high.
REQ-026 SHALL assert done in FIN, one cycle after the last accepted write, with num_blocks = P/BLOCK_BYTES.
REQ-027 SHALL, for msg_len mod BLOCK_BYTES = BLOCK_BYTES-1-LEN_BYTES (55 by default), write 0x80 immediately followed by the length field with no zeros.
REQ-028 SHALL, for msg_len mod BLOCK_BYTES > BLOCK_BYTES-1-LEN_BYTES, spill into one extra block.
REQ-029 SHALL, for msg_len = 0, write exactly one block: 0x80, BLOCK_BYTES-1-LEN_BYTES zeros, and a length field of 0.

Reset
REQ-030 SHALL, on rst at any time including mid-message, force IDLE next cycle with mem_we=0, busy=0, done=0, error=0, mem_addr=0, mem_wdata=0 and num_blocks=0; an aborted message is not resumed.

Verification
REQ-031 SHALL cover this case: base=0, len=3, mem_ready=1 -> addr 3=0x80, addrs 4..55=0x00, 56..62=0x00, 63=0x18; done at cycle 63 after start; num_blocks=1.
REQ-032 SHALL cover this case: len=55 -> addr 55=0x80, then the length field 0x00..0x01,0xB8; no zero bytes written; num_blocks=1.
REQ-033 SHALL cover this case: len=56 -> 72 writes; the last byte at address 127 is 0xC0; num_blocks=2.
REQ-034 SHALL cover this case: base=1000, len=10 -> error pulse and zero writes; done never asserts.
REQ-035 SHALL cover this case: mem_ready held low for 5 cycles mid-ZERO -> outputs stable, no byte skipped or duplicated, done delayed 5 cycles.
REQ-036 SHALL cover this case: rst asserted during LEN, followed by a new start with len=0 -> clean 64-byte pad; no residue from the aborted run.

Source files
------------

// File: rtl/msg_pad_engine.sv
// ---------------------------------------------------------------------------
// msg_pad_engine
//
// Purpose:
//    Appends hash-style padding to a message already held in a byte-wide
//    memory. For a message of msg_len bytes at base_addr it writes a single
//    0x80 marker byte, then enough 0x00 bytes, then a big-endian bit-length
//    field. The result is a padded length that is a whole number of
//    BLOCK_BYTES blocks. A request whose padded image would run past the
//    top of the address space is rejected without touching memory.
//
// Ports:
//    clk         in   clock, rising edge
//    rst         in   synchronous active-high reset
//    start       in   pad request, sampled only while idle
//    base_addr   in   byte address of message byte 0
//    msg_len     in   message length in bytes
//    mem_we      out  write request
//    mem_addr    out  write byte address
//    mem_wdata   out  write data byte
//    mem_ready   in   memory accepts the presented write this cycle
//    busy        out  high whenever the engine is not idle
//    done        out  one-cycle pulse after the last padding byte is accepted
//    error       out  one-cycle pulse when a request is rejected
//    num_blocks  out  padded length in blocks, valid from done to next start
// ---------------------------------------------------------------------------
module msg_pad_engine #(
    parameter int ADDR_WIDTH  = 10,
    parameter int BLOCK_BYTES = 64,
    parameter int LEN_BYTES   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] msg_len,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] num_blocks
);

    // Length arithmetic is two bits wider than an address so neither the
    // padded length nor base+padded can wrap.
    localparam int CW        = ADDR_WIDTH + 2;
    localparam int LB        = LEN_BYTES * 8;
    localparam int BLK_SHIFT = $clog2(BLOCK_BYTES);
    localparam int LCW       = $clog2(LEN_BYTES + 1);
    localparam int LENW      = ADDR_WIDTH + 3;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        PAD80,
        ZERO,
        LEN,
        FIN
    } state_t;

    state_t                r_state;
    state_t                w_nextState;

    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_len;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CW-1:0]         r_zeroCnt;
    logic [LB-1:0]         r_lenShift;
    logic [LCW-1:0]        r_lenCnt;
    logic [ADDR_WIDTH-1:0] r_numBlocks;

    logic [CW-1:0]         w_need;
    logic [CW-1:0]         w_padLen;
    logic [CW-1:0]         w_zeroCnt;
    logic [CW:0]           w_endAddr;
    logic                  w_reject;
    logic [LENW-1:0]       w_lenBits;
    logic [ADDR_WIDTH-1:0] w_numBlocksCalc;
    logic                  w_memWe;
    logic                  w_accept;

    // Padded-length calculation, evaluated from the latched request while in
    // CALC. The rounding works because BLOCK_BYTES is a power of two.
    always_comb begin
        w_need          = CW'(r_len) + CW'(1 + LEN_BYTES);
        w_padLen        = (w_need + CW'(BLOCK_BYTES - 1)) & ~CW'(BLOCK_BYTES - 1);
        w_zeroCnt       = w_padLen - CW'(r_len) - CW'(1 + LEN_BYTES);
        w_endAddr       = (CW + 1)'(r_base) + (CW + 1)'(w_padLen);
        w_reject        = w_endAddr > ((CW + 1)'(1) << ADDR_WIDTH);
        w_lenBits       = {r_len, 3'b000};
        w_numBlocksCalc = ADDR_WIDTH'(w_padLen >> BLK_SHIFT);
    end

    assign w_accept = w_memWe & mem_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Write states only advance on an accepted write, so a
    // stalled memory simply freezes the engine where it is.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:  if (start) w_nextState = CALC;
            CALC:  w_nextState = w_reject ? IDLE : PAD80;
            PAD80: if (w_accept) w_nextState = (r_zeroCnt == '0) ? LEN : ZERO;
            ZERO:  if (w_accept && (r_zeroCnt == CW'(1))) w_nextState = LEN;
            LEN:   if (w_accept && (r_lenCnt == LCW'(1))) w_nextState = FIN;
            FIN:   w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Output decode. Address and data are forced to zero whenever no write
    // is requested so the bus is quiet while idle.
    always_comb begin
        w_memWe   = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        busy      = (r_state != IDLE);
        done      = (r_state == FIN);
        error     = (r_state == CALC) && w_reject;
        unique case (r_state)
            PAD80: begin
                w_memWe   = 1'b1;
                mem_addr  = r_addr;
                mem_wdata = 8'h80;
            end
            ZERO: begin
                w_memWe   = 1'b1;
                mem_addr  = r_addr;
                mem_wdata = 8'h00;
            end
            LEN: begin
                w_memWe   = 1'b1;
                mem_addr  = r_addr;
                mem_wdata = r_lenShift[LB-1 -: 8];
            end
            default: begin
                w_memWe   = 1'b0;
            end
        endcase
    end

    assign mem_we     = w_memWe;
    assign num_blocks = r_numBlocks;

    // Request and write-pointer registers. The three write phases share one
    // incrementing address because marker, zeros and length field are
    // contiguous. The length field is shifted out MSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base      <= '0;
            r_len       <= '0;
            r_addr      <= '0;
            r_zeroCnt   <= '0;
            r_lenShift  <= '0;
            r_lenCnt    <= '0;
            r_numBlocks <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base      <= base_addr;
                        r_len       <= msg_len;
                        r_numBlocks <= '0;
                    end
                end
                CALC: begin
                    r_addr     <= r_base + r_len;
                    r_zeroCnt  <= w_zeroCnt;
                    r_lenShift <= LB'(w_lenBits);
                    r_lenCnt   <= LCW'(LEN_BYTES);
                    if (!w_reject) begin
                        r_numBlocks <= w_numBlocksCalc;
                    end
                end
                PAD80: begin
                    if (w_accept) begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                    end
                end
                ZERO: begin
                    if (w_accept) begin
                        r_addr    <= r_addr + ADDR_WIDTH'(1);
                        r_zeroCnt <= r_zeroCnt - CW'(1);
                    end
                end
                LEN: begin
                    if (w_accept) begin
                        r_addr     <= r_addr + ADDR_WIDTH'(1);
                        r_lenShift <= r_lenShift << 8;
                        r_lenCnt   <= r_lenCnt - LCW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_pad_engine.sv
module tb_msg_pad_engine;

    localparam int AW   = 10;
    localparam int MAXC = 400;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] msg_len;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_ready;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] num_blocks;

    int checks;
    int failures;

    int wAddr[$];
    int wData[$];
    int doneCyc;
    int errCyc;
    int nbAtDone;
    int busy1;
    int stallBad;
    int stallAddr;

    typedef struct {
        int base;
        int len;
        int expWrites;
        int expNb;
        int expErr;
        int expDone;
        int expLast;
    } vec_t;

    vec_t vecs[8];

    msg_pad_engine #(
        .ADDR_WIDTH (AW),
        .BLOCK_BYTES(64),
        .LEN_BYTES  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .msg_len   (msg_len),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .num_blocks(num_blocks)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports a failure line on mismatch.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // Reference model of the padded image: the byte expected at write index i.
    function automatic int expectedByte(input int base, input int len, input int i);
        int p;
        int addr;
        int lenStart;
        int k;
        longint bits;
        p        = ((len + 1 + 8 + 63) / 64) * 64;
        addr     = base + len + i;
        lenStart = base + p - 8;
        bits     = longint'(len) * 8;
        if (i == 0) return 8'h80;
        if (addr < lenStart) return 0;
        k = addr - lenStart;
        return int'((bits >> (8 * (7 - k))) & 64'hFF);
    endfunction

    // Counts writes whose address or data differ from the model sequence.
    function automatic int badWrites(input int base, input int len);
        int bad;
        bad = 0;
        for (int i = 0; i < wAddr.size(); i++) begin
            if (wAddr[i] != base + len + i) bad++;
            else if (wData[i] != expectedByte(base, len, i)) bad++;
        end
        return bad;
    endfunction

    // Issues one start and watches the bus cycle by cycle. Cycle n is the
    // n-th falling edge after the edge that samples start. mem_ready is
    // dropped for stallLen cycles beginning at stallFrom; if abortAt is
    // reached, rst is raised there and the run stops.
    task automatic applyStimulus(input int base, input int len, input int stallFrom,
                                 input int stallLen, input int abortAt);
        int heldAddr;
        int heldData;
        wAddr.delete();
        wData.delete();
        doneCyc   = -1;
        errCyc    = -1;
        nbAtDone  = -1;
        busy1     = -1;
        stallBad  = 0;
        stallAddr = -1;
        heldAddr  = 0;
        heldData  = 0;
        @(negedge clk);
        base_addr = AW'(base);
        msg_len   = AW'(len);
        mem_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= MAXC; n++) begin
            @(negedge clk);
            mem_ready = (n >= stallFrom && n < stallFrom + stallLen) ? 1'b0 : 1'b1;
            if (n == 1) busy1 = int'(busy);
            if (n == stallFrom) begin
                heldAddr  = int'(mem_addr);
                heldData  = int'(mem_wdata);
                stallAddr = heldAddr;
            end
            if (n >= stallFrom && n < stallFrom + stallLen) begin
                if (!mem_we || int'(mem_addr) != heldAddr || int'(mem_wdata) != heldData)
                    stallBad++;
            end
            if (mem_we && mem_ready) begin
                wAddr.push_back(int'(mem_addr));
                wData.push_back(int'(mem_wdata));
            end
            if (error && errCyc < 0) errCyc = n;
            if (done) begin
                doneCyc  = n;
                nbAtDone = int'(num_blocks);
                break;
            end
            if (errCyc >= 0 && n >= errCyc + 10) break;
            if (n == abortAt) begin
                rst = 1'b1;
                break;
            end
        end
        mem_ready = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        msg_len   = '0;
        mem_ready = 1'b1;

        //          base  len  writes nb err done last
        vecs[0] = '{0,    3,   61,    1,  0,  63,  8'h18};
        vecs[1] = '{0,    55,  9,     1,  0,  11,  8'hB8};
        vecs[2] = '{0,    56,  72,    2,  0,  74,  8'hC0};
        vecs[3] = '{1000, 10,  0,     0,  1,  -1,  -1};
        vecs[4] = '{0,    0,   64,    1,  0,  66,  8'h00};
        vecs[5] = '{960,  0,   64,    1,  0,  66,  8'h00};
        vecs[6] = '{100,  200, 56,    4,  0,  58,  8'h40};
        vecs[7] = '{1016, 0,   0,     0,  1,  -1,  -1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset mem_we", int'(mem_we), 0);
        checkOutput("reset num_blocks", int'(num_blocks), 0);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].base, vecs[v].len, MAXC + 10, 0, MAXC + 10);
            $display("[TB] vector %0d base=%0d len=%0d writes=%0d", v, vecs[v].base,
                     vecs[v].len, wAddr.size());
            checkOutput($sformatf("v%0d busy", v), busy1, 1);
            checkOutput($sformatf("v%0d writes", v), wAddr.size(), vecs[v].expWrites);
            checkOutput($sformatf("v%0d error cycle", v), errCyc, vecs[v].expErr ? 1 : -1);
            checkOutput($sformatf("v%0d done cycle", v), doneCyc, vecs[v].expDone);
            if (!vecs[v].expErr) begin
                checkOutput($sformatf("v%0d num_blocks", v), nbAtDone, vecs[v].expNb);
                checkOutput($sformatf("v%0d sequence", v), badWrites(vecs[v].base, vecs[v].len), 0);
                checkOutput($sformatf("v%0d last byte", v), wData[wData.size() - 1], vecs[v].expLast);
            end
            repeat (2) @(negedge clk);
        end

        // Memory stalls for 5 cycles in the middle of the zero run.
        applyStimulus(0, 3, 10, 5, MAXC + 10);
        checkOutput("stall writes", wAddr.size(), 61);
        checkOutput("stall sequence", badWrites(0, 3), 0);
        checkOutput("stall held outputs", stallBad, 0);
        checkOutput("stall address", stallAddr, 11);
        checkOutput("stall done cycle", doneCyc, 68);
        checkOutput("stall num_blocks", nbAtDone, 1);
        repeat (2) @(negedge clk);

        // Reset while the length field is being written, then a fresh pad.
        applyStimulus(0, 3, MAXC + 10, 0, 58);
        checkOutput("abort in LEN addr", wAddr[wAddr.size() - 1], 59);
        @(negedge clk);
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort mem_we", int'(mem_we), 0);
        checkOutput("abort mem_addr", int'(mem_addr), 0);
        checkOutput("abort mem_wdata", int'(mem_wdata), 0);
        checkOutput("abort done", int'(done), 0);
        checkOutput("abort num_blocks", int'(num_blocks), 0);
        rst = 1'b0;
        applyStimulus(0, 0, MAXC + 10, 0, MAXC + 10);
        checkOutput("after abort writes", wAddr.size(), 64);
        checkOutput("after abort sequence", badWrites(0, 0), 0);
        checkOutput("after abort done cycle", doneCyc, 66);
        checkOutput("after abort num_blocks", nbAtDone, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
